// File: rtl/cart_bus_initiator.sv
// Atari 8-bit cartridge-slot bus master: free-running phi2 plus one
// CPU-style bus cycle (strobes, address, r/w, data) per host request.
module cart_bus_initiator #(
  parameter int unsigned HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        phi2,
  output logic [12:0] cart_a,
  inout  wire  [7:0]  cart_d,
  output logic        s4_n,
  output logic        s5_n,
  output logic        cctl_n,
  output logic        r_w,
  input  logic        rd4,
  input  logic        rd5
);

  localparam int unsigned CNT_W = $clog2(HALF);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_LOW, S_HIGH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phi2_q, phi2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [12:0]        cart_a_q, cart_a_d;
  logic               s4_n_q, s4_n_d;
  logic               s5_n_q, s5_n_d;
  logic               cctl_n_q, cctl_n_d;
  logic               r_w_q, r_w_d;
  logic               drive_q, drive_d;
  logic [7:0]         wd_q, wd_d;
  logic               req_we_q, req_we_d;
  logic [15:0]        req_addr_q, req_addr_d;
  logic [7:0]         req_wdata_q, req_wdata_d;

  logic               phase_end, phi2_fall, phi2_rise, launch;
  logic               sel_we;
  logic [15:0]        sel_addr;
  logic [7:0]         sel_wdata;

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign phi2   = phi2_q;
  assign cart_a = cart_a_q;
  assign s4_n   = s4_n_q;
  assign s5_n   = s5_n_q;
  assign cctl_n = cctl_n_q;
  assign r_w    = r_w_q;
  assign cart_d = drive_q ? wd_q : 8'hzz;

  // Next-state logic: phi2 divider, bus-cycle sequencing and bus outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    phi2_d      = phi2_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    cart_a_d    = cart_a_q;
    s4_n_d      = s4_n_q;
    s5_n_d      = s5_n_q;
    cctl_n_d    = cctl_n_q;
    r_w_d       = r_w_q;
    drive_d     = drive_q;
    wd_d        = wd_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    launch      = 1'b0;

    phase_end = (cnt_q == CNT_MAX);
    phi2_fall = phase_end & phi2_q;
    phi2_rise = phase_end & ~phi2_q;
    if (phase_end) begin
      cnt_d  = '0;
      phi2_d = ~phi2_q;
    end

    // A request arriving in IDLE on a phi2 fall launches straight from the inputs.
    sel_we    = (state_q == S_IDLE) ? we    : req_we_q;
    sel_addr  = (state_q == S_IDLE) ? addr  : req_addr_q;
    sel_wdata = (state_q == S_IDLE) ? wdata : req_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          req_we_d    = we;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          if (phi2_fall) launch = 1'b1;
          else           state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (phi2_fall) launch = 1'b1;
      end
      S_LOW: begin
        if (phi2_rise) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (phi2_fall) begin
          if (r_w_q) begin
            rdata_d = (!s4_n_q || !s5_n_q || !cctl_n_q) ? cart_d : 8'hFF;
          end
          s4_n_d   = 1'b1;
          s5_n_d   = 1'b1;
          cctl_n_d = 1'b1;
          r_w_d    = 1'b1;
          drive_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d  = S_LOW;
      cart_a_d = sel_addr[12:0];
      r_w_d    = ~sel_we;
      s4_n_d   = ~((sel_addr[15:13] == 3'b100) & rd4);
      s5_n_d   = ~((sel_addr[15:13] == 3'b101) & rd5);
      cctl_n_d = ~(sel_addr[15:8] == 8'hD5);
      drive_d  = sel_we;
      wd_d     = sel_wdata;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phi2_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 8'hFF;
      cart_a_q    <= '0;
      s4_n_q      <= 1'b1;
      s5_n_q      <= 1'b1;
      cctl_n_q    <= 1'b1;
      r_w_q       <= 1'b1;
      drive_q     <= 1'b0;
      wd_q        <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phi2_q      <= phi2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      cart_a_q    <= cart_a_d;
      s4_n_q      <= s4_n_d;
      s5_n_q      <= s5_n_d;
      cctl_n_q    <= cctl_n_d;
      r_w_q       <= r_w_d;
      drive_q     <= drive_d;
      wd_q        <= wd_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

endmodule
